maze_neighbor_scanner: RTL and testbench

Initiator for the 16x16 maze bit-map memory. On `start`, the block reads the four orthogonal neighbours of a given cell and returns a 4-bit open-direction mask. It can optionally mark the current cell visited first. It sits between the maze-solving controller and the maze memory, and owns the memory's `x/y/rd/wr/dIn` inputs while consuming its `dOut`.

---
 rtl/maze_neighbor_scanner.sv | 165 ++++++++++++++++
 tb/tb_maze_neighbor_scanner.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_neighbor_scanner.sv
// rtl/maze_neighbor_scanner.sv - probes the four neighbours of a maze cell and returns an open-direction mask
//
// Purpose: memory initiator for the 16x16 maze bit-map. On an accepted start it
// reads the N, E, S, W neighbours of (cur_x, cur_y) and reports which are open.
// Out-of-map neighbours are never read and always report blocked.
//
// Optional feature macro: MAZE_MARK_VISITED_EN
//   defined   - the current cell is written with WALL (one cycle) before probing
//   undefined - no write is ever issued; o_mem_wr and o_mem_din stay 0
//
// Ports:
//   i_clk        clock shared with the maze memory
//   i_rst_n      asynchronous active-low reset
//   i_start      request pulse, sampled only while idle
//   i_cur_x/y    current cell, latched on an accepted start
//   o_busy       high whenever a scan is in progress
//   o_done       one-cycle pulse; o_open_mask is valid from this cycle on
//   o_open_mask  bit0 N (y-1), bit1 E (x+1), bit2 S (y+1), bit3 W (x-1); 1 = open
//   o_mem_x/y    memory address (0 when no strobe is active)
//   o_mem_rd     memory read strobe
//   o_mem_wr     memory write strobe
//   o_mem_din    memory write data
//   i_mem_dout   memory read data, valid the cycle after o_mem_rd

module maze_neighbor_scanner #(
    parameter logic WALL = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [3:0] i_cur_x,
    input  logic [3:0] i_cur_y,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_open_mask,
    output logic [3:0] o_mem_x,
    output logic [3:0] o_mem_y,
    output logic       o_mem_rd,
    output logic       o_mem_wr,
    output logic       o_mem_din,
    input  logic       i_mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_PROBE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [1:0] r_dir;
    logic [3:0] r_cur_x;
    logic [3:0] r_cur_y;
    logic [3:0] r_mask;
    logic [3:0] r_open_mask;

    logic [4:0] w_nbr_x;
    logic [4:0] w_nbr_y;
    logic       w_nbr_oob;
    logic       w_probe_rd;
    logic       w_mark;
    logic [3:0] w_mask_next;

    // Neighbour address in 5 bits: both -1 (5'b11111) and 16 (5'b10000) set
    // bit 4, so a single bit flags out-of-map without any wrap-around.
    always_comb begin
        w_nbr_x = {1'b0, r_cur_x};
        w_nbr_y = {1'b0, r_cur_y};
        case (r_dir)
            2'd0:    w_nbr_y = {1'b0, r_cur_y} - 5'd1;
            2'd1:    w_nbr_x = {1'b0, r_cur_x} + 5'd1;
            2'd2:    w_nbr_y = {1'b0, r_cur_y} + 5'd1;
            default: w_nbr_x = {1'b0, r_cur_x} - 5'd1;
        endcase
    end

    assign w_nbr_oob  = w_nbr_x[4] | w_nbr_y[4];
    assign w_probe_rd = (r_state == S_PROBE) && !w_nbr_oob;

`ifdef MAZE_MARK_VISITED_EN
    assign w_mark = (r_state == S_MARK);
`else
    assign w_mark = 1'b0;
`endif

    // Mask with the current direction's bit resolved: open only when WAIT
    // sees a non-WALL read; a PROBE that reaches here was out of the map.
    always_comb begin
        w_mask_next        = r_mask;
        w_mask_next[r_dir] = (r_state == S_WAIT) && (i_mem_dout != WALL);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_dir       <= 2'd0;
            r_cur_x     <= 4'd0;
            r_cur_y     <= 4'd0;
            r_mask      <= 4'd0;
            r_open_mask <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cur_x <= i_cur_x;
                        r_cur_y <= i_cur_y;
                        r_mask  <= 4'd0;
                        r_dir   <= 2'd0;
`ifdef MAZE_MARK_VISITED_EN
                        r_state <= S_MARK;
`else
                        r_state <= S_PROBE;
`endif
                    end
                end
                S_MARK: begin
                    r_dir   <= 2'd0;
                    r_state <= S_PROBE;
                end
                S_PROBE: begin
                    if (!w_nbr_oob) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_mask <= w_mask_next;
                        if (r_dir == 2'd3) begin
                            r_open_mask <= w_mask_next;
                            r_state     <= S_DONE;
                        end else begin
                            r_dir <= r_dir + 2'd1;
                        end
                    end
                end
                S_WAIT: begin
                    r_mask <= w_mask_next;
                    if (r_dir == 2'd3) begin
                        // Published on entry to DONE so it is valid with o_done.
                        r_open_mask <= w_mask_next;
                        r_state     <= S_DONE;
                    end else begin
                        r_dir   <= r_dir + 2'd1;
                        r_state <= S_PROBE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_open_mask = r_open_mask;
    assign o_mem_rd    = w_probe_rd;
    assign o_mem_wr    = w_mark;
    assign o_mem_din   = w_mark & WALL;
    assign o_mem_x     = w_probe_rd ? w_nbr_x[3:0] : (w_mark ? r_cur_x : 4'd0);
    assign o_mem_y     = w_probe_rd ? w_nbr_y[3:0] : (w_mark ? r_cur_y : 4'd0);

endmodule

// File: tb/tb_maze_neighbor_scanner.sv
// tb/tb_maze_neighbor_scanner.sv - self-checking bench for maze_neighbor_scanner

module tb_maze_neighbor_scanner;

    localparam logic WALL = 1'b1;
`ifdef MAZE_MARK_VISITED_EN
    localparam int MARK_CYC = 1;
`else
    localparam int MARK_CYC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] cur_x = 4'd0;
    logic [3:0] cur_y = 4'd0;
    logic       busy, done;
    logic [3:0] open_mask, mem_x, mem_y;
    logic       mem_rd, mem_wr, mem_din;
    logic       mem_dout;

    always #5 clk = ~clk;

    maze_neighbor_scanner #(.WALL(WALL)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_cur_x     (cur_x),
        .i_cur_y     (cur_y),
        .o_busy      (busy),
        .o_done      (done),
        .o_open_mask (open_mask),
        .o_mem_x     (mem_x),
        .o_mem_y     (mem_y),
        .o_mem_rd    (mem_rd),
        .o_mem_wr    (mem_wr),
        .o_mem_din   (mem_din),
        .i_mem_dout  (mem_dout)
    );

    // Maze memory model and bus monitor: strobes sampled at negedge, applied at posedge.
    logic       map [16][16];
    logic [9:0] ev_q[$];
    logic [9:0] exp_ev[$];
    bit         illegal = 0;
    logic       p_rd, p_wr, p_din;
    logic [3:0] p_x, p_y;

    always @(negedge clk) begin
        p_rd  = mem_rd;
        p_wr  = mem_wr;
        p_din = mem_din;
        p_x   = mem_x;
        p_y   = mem_y;
        if (mem_rd && mem_wr) illegal = 1;
        if (mem_din && !mem_wr) illegal = 1;
        if (!mem_rd && !mem_wr && (mem_x != 0 || mem_y != 0)) illegal = 1;
        if (mem_rd || mem_wr) ev_q.push_back({mem_wr, mem_din, mem_x, mem_y});
    end

    always @(posedge clk) begin
        if (p_rd) mem_dout <= map[p_x][p_y];
        if (p_wr) map[p_x][p_y] <= p_din;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit nbr(input int x, input int y, input int d, output int nx, output int ny);
        nx = x;
        ny = y;
        case (d)
            0:       ny = y - 1;
            1:       nx = x + 1;
            2:       ny = y + 1;
            default: nx = x - 1;
        endcase
        return (nx >= 0 && nx < 16 && ny >= 0 && ny < 16);
    endfunction

    // Reference: expected mask, latency and bus event sequence from the current map.
    function automatic logic [3:0] model(input int x, input int y, output int lat);
        logic [3:0] m;
        int nx, ny;
        m   = 4'd0;
        lat = 1 + MARK_CYC;
        exp_ev.delete();
        if (MARK_CYC == 1) exp_ev.push_back({1'b1, WALL, 4'(x), 4'(y)});
        for (int d = 0; d < 4; d++) begin
            if (nbr(x, y, d, nx, ny)) begin
                m[d] = (map[nx][ny] != WALL);
                lat += 2;
                exp_ev.push_back({2'b00, 4'(nx), 4'(ny)});
            end else begin
                lat += 1;
            end
        end
        return m;
    endfunction

    function automatic int n_reads();
        int n = 0;
        foreach (ev_q[i]) if (ev_q[i][9] == 1'b0) n++;
        return n;
    endfunction

    task automatic cmp_events(input string name);
        int bad = 0;
        chk({name, " ev_count"}, ev_q.size(), exp_ev.size());
        for (int i = 0; i < ev_q.size() && i < exp_ev.size(); i++)
            if (ev_q[i] !== exp_ev[i]) bad++;
        chk({name, " ev_seq"}, bad, 0);
    endtask

    // Called one step after a posedge with the DUT idle; returns one step after
    // the posedge that ends DONE, so consecutive calls start back-to-back.
    task automatic do_scan(input logic [3:0] x, input logic [3:0] y,
                           output logic [3:0] mask, output int lat,
                           output bit to, output bit hold_bad);
        logic [3:0] held;
        ev_q.delete();
        held     = open_mask;
        hold_bad = 0;
        to       = 0;
        cur_x    = x;
        cur_y    = y;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (done) break;
            if (open_mask !== held || !busy) hold_bad = 1;
            if (lat >= 40) begin
                to = 1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        mask = open_mask;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] nb;
        logic [3:0] mask;
        int         lat;
    } vec_t;

    initial begin
        vec_t       tbl[6];
        logic [3:0] m, em;
        int         lat, elat, nx, ny, k, seen;
        bit         to, hb;
        string      nm;

        tbl[0] = '{4'd7,  4'd7,  4'b1010, 4'b0101, 9};
        tbl[1] = '{4'd0,  4'd0,  4'b0000, 4'b0110, 7};
        tbl[2] = '{4'd15, 4'd15, 4'b1111, 4'b0000, 7};
        tbl[3] = '{4'd0,  4'd15, 4'b0010, 4'b0001, 7};
        tbl[4] = '{4'd15, 4'd0,  4'b0000, 4'b1100, 7};
        tbl[5] = '{4'd8,  4'd0,  4'b0000, 4'b1110, 8};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset mask", open_mask, 0);
        chk("reset mem", {mem_x, mem_y, mem_rd, mem_wr, mem_din}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) map[a][b] = 1'($urandom_range(0, 1));
            for (int d = 0; d < 4; d++)
                if (nbr(tbl[i].x, tbl[i].y, d, nx, ny)) map[nx][ny] = tbl[i].nb[d];
            em = model(tbl[i].x, tbl[i].y, elat);
            do_scan(tbl[i].x, tbl[i].y, m, lat, to, hb);
            nm = $sformatf("vec%0d", i);
            chk({nm, " timeout"}, to, 0);
            chk({nm, " mask"}, m, tbl[i].mask);
            chk({nm, " latency"}, lat, tbl[i].lat + MARK_CYC);
            chk({nm, " hold"}, hb, 0);
            chk({nm, " idle_after"}, {busy, done}, 0);
            cmp_events(nm);
        end

`ifdef MAZE_MARK_VISITED_EN
        map[3][4] = 1'b0;
        em = model(3, 4, elat);
        do_scan(4'd3, 4'd4, m, lat, to, hb);
        chk("mark latency", lat, 10);
        chk("mark readback", map[3][4], 1);
        cmp_events("mark");
`endif

        for (int i = 0; i < 25; i++) begin
            logic [3:0] rx, ry;
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) map[a][b] = 1'($urandom_range(0, 1));
            rx = 4'($urandom_range(0, 15));
            ry = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rx = ($urandom_range(0, 1) == 1) ? 4'd15 : 4'd0;
            if ($urandom_range(0, 3) == 0) ry = ($urandom_range(0, 1) == 1) ? 4'd15 : 4'd0;
            em = model(rx, ry, elat);
            do_scan(rx, ry, m, lat, to, hb);
            nm = $sformatf("rnd%0d(%0d,%0d)", i, rx, ry);
            chk({nm, " mask"}, m, em);
            chk({nm, " latency"}, lat, elat);
            cmp_events(nm);
        end

        // Re-pulse while busy, then reset after the second read.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) map[a][b] = 1'b0;
        do_scan(4'd7, 4'd7, m, lat, to, hb);
        chk("pre_reset mask", m, 4'b1111);
        em = model(5, 5, elat);
        ev_q.delete();
        cur_x = 4'd5;
        cur_y = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cur_x = 4'd0;
        cur_y = 4'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (n_reads() < 2 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("second read seen", n_reads(), 2);
        rst_n = 1'b0;
        #1;
        chk("reset outputs", {busy, done, open_mask, mem_x, mem_y, mem_rd, mem_wr, mem_din}, 0);
        k = 0;
        for (int i = 0; i < ev_q.size() && i < exp_ev.size(); i++)
            if (ev_q[i] !== exp_ev[i]) k++;
        chk("repulse ignored", k, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("no done after reset", seen, 0);
        @(posedge clk);
        #1;
        em = model(5, 5, elat);
        do_scan(4'd5, 4'd5, m, lat, to, hb);
        chk("post_reset mask", m, em);
        chk("post_reset latency", lat, elat);
        chk("post_reset hold", hb, 0);
        cmp_events("post_reset");

        chk("strobe rules", illegal, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
